// File: rtl/operand_forward_stage.sv
// R->C operand register with forward muxing and stall-safe hold of forwarded compute results.
// Optional statistics counters are built only when FORWARD_STATS_EN is defined.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package HighLevelControl;
   typedef enum logic [1:0] {
      NO_FORWARD       = 2'd0,
      COMPUTE_RESULT   = 2'd1,
      TRUNCATED_RESULT = 2'd2
   } fwd_src_e;
   typedef fwd_src_e rs1ForwardSrc;
   typedef fwd_src_e rs2ForwardSrc;
endpackage

module operand_forward_stage #(
   parameter int unsigned WIDTH = `WORD_SIZE
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [WIDTH-1:0]              rs1Data_R,
   input  logic [WIDTH-1:0]              rs2Data_R,
   input  logic                          Valid_R,
   input  HighLevelControl::rs1ForwardSrc Rs1ForwardSrc,
   input  HighLevelControl::rs2ForwardSrc Rs2ForwardSrc,
   input  logic [WIDTH-1:0]              ComputeResult_M,
   input  logic [WIDTH-1:0]              TruncatedResult_W,
   input  logic                          StallRC,
   input  logic                          FlushCM,
   output logic [WIDTH-1:0]              Rs1Op_C,
   output logic [WIDTH-1:0]              Rs2Op_C,
   output logic                          Valid_C,
   output logic                          Valid_M,
   output logic [31:0]                   StallCycles,
   output logic [31:0]                   ForwardCount
);
   import HighLevelControl::*;

   localparam int unsigned STAT_W = 32;

   typedef enum logic {LIVE = 1'b0, HELD = 1'b1} op_state_e;

   op_state_e        r_rs1_state, r_rs2_state;
   op_state_e        w_rs1_state_nxt, w_rs2_state_nxt;
   logic [WIDTH-1:0] r_rs1_val, r_rs2_val;
   logic [WIDTH-1:0] r_rs1_hold, r_rs2_hold;
   logic [WIDTH-1:0] w_rs1_hold_nxt, w_rs2_hold_nxt;
   logic             r_valid_c, r_valid_m;

   // Pipeline registers, operand FSM state and hold registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rs1_val   <= '0;
         r_rs2_val   <= '0;
         r_valid_c   <= 1'b0;
         r_valid_m   <= 1'b0;
         r_rs1_state <= LIVE;
         r_rs2_state <= LIVE;
         r_rs1_hold  <= '0;
         r_rs2_hold  <= '0;
      end else begin
         if (!StallRC) begin
            r_rs1_val <= rs1Data_R;
            r_rs2_val <= rs2Data_R;
            r_valid_c <= Valid_R;
         end
         r_valid_m   <= FlushCM ? 1'b0 : r_valid_c;
         r_rs1_state <= w_rs1_state_nxt;
         r_rs2_state <= w_rs2_state_nxt;
         r_rs1_hold  <= w_rs1_hold_nxt;
         r_rs2_hold  <= w_rs2_hold_nxt;
      end
   end

   // Only a valid instruction stalled on a compute forward captures; truncated results are never held
   always_comb begin
      w_rs1_state_nxt = r_rs1_state;
      w_rs2_state_nxt = r_rs2_state;
      w_rs1_hold_nxt  = r_rs1_hold;
      w_rs2_hold_nxt  = r_rs2_hold;
      case (r_rs1_state)
         LIVE: if (StallRC && r_valid_c && (Rs1ForwardSrc == COMPUTE_RESULT)) begin
            w_rs1_state_nxt = HELD;
            w_rs1_hold_nxt  = ComputeResult_M;
         end
         HELD: if (!StallRC) w_rs1_state_nxt = LIVE;
      endcase
      case (r_rs2_state)
         LIVE: if (StallRC && r_valid_c && (Rs2ForwardSrc == COMPUTE_RESULT)) begin
            w_rs2_state_nxt = HELD;
            w_rs2_hold_nxt  = ComputeResult_M;
         end
         HELD: if (!StallRC) w_rs2_state_nxt = LIVE;
      endcase
   end

   function automatic logic [WIDTH-1:0] f_op_sel(
      input op_state_e        st,
      input fwd_src_e         src,
      input logic [WIDTH-1:0] hold,
      input logic [WIDTH-1:0] val,
      input logic [WIDTH-1:0] cres,
      input logic [WIDTH-1:0] tres
   );
      logic [WIDTH-1:0] res;
      res = val;
      if (st == HELD) begin
         res = hold;
      end else begin
         case (src)
            COMPUTE_RESULT:   res = cres;
            TRUNCATED_RESULT: res = tres;
            default:          res = val;
         endcase
      end
      return res;
   endfunction

   assign Rs1Op_C = f_op_sel(r_rs1_state, Rs1ForwardSrc, r_rs1_hold, r_rs1_val,
                             ComputeResult_M, TruncatedResult_W);
   assign Rs2Op_C = f_op_sel(r_rs2_state, Rs2ForwardSrc, r_rs2_hold, r_rs2_val,
                             ComputeResult_M, TruncatedResult_W);
   assign Valid_C = r_valid_c;
   assign Valid_M = r_valid_m;

`ifdef FORWARD_STATS_EN
   logic [STAT_W-1:0] r_stall_cycles, r_fwd_count;

   // Free-running statistics, wrap naturally at 2^32
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_stall_cycles <= '0;
         r_fwd_count    <= '0;
      end else begin
         if (StallRC)
            r_stall_cycles <= r_stall_cycles + STAT_W'(1);
         if (r_valid_c && !StallRC &&
             ((Rs1ForwardSrc != NO_FORWARD) || (Rs2ForwardSrc != NO_FORWARD)))
            r_fwd_count <= r_fwd_count + STAT_W'(1);
      end
   end

   assign StallCycles  = r_stall_cycles;
   assign ForwardCount = r_fwd_count;
`else
   assign StallCycles  = STAT_W'(0);
   assign ForwardCount = STAT_W'(0);
`endif

endmodule

// File: tb/tb_operand_forward_stage.sv
// Directed self-checking bench for operand_forward_stage.
`timescale 1ns/1ps
module tb_operand_forward_stage;
   import HighLevelControl::*;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  rs1Data_R, rs2Data_R;
   logic          Valid_R;
   fwd_src_e      Rs1ForwardSrc, Rs2ForwardSrc;
   logic [W-1:0]  ComputeResult_M, TruncatedResult_W;
   logic          StallRC, FlushCM;
   logic [W-1:0]  Rs1Op_C, Rs2Op_C;
   logic          Valid_C, Valid_M;
   logic [31:0]   StallCycles, ForwardCount;

   int n_checks = 0;
   int n_fail   = 0;

   operand_forward_stage #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .rs1Data_R(rs1Data_R), .rs2Data_R(rs2Data_R), .Valid_R(Valid_R),
      .Rs1ForwardSrc(Rs1ForwardSrc), .Rs2ForwardSrc(Rs2ForwardSrc),
      .ComputeResult_M(ComputeResult_M), .TruncatedResult_W(TruncatedResult_W),
      .StallRC(StallRC), .FlushCM(FlushCM),
      .Rs1Op_C(Rs1Op_C), .Rs2Op_C(Rs2Op_C), .Valid_C(Valid_C), .Valid_M(Valid_M),
      .StallCycles(StallCycles), .ForwardCount(ForwardCount)
   );

   always #5 clk = ~clk;

   // Inputs change 1ns after a rising edge; checks happen 1ns after that
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b1; rs1Data_R = '0; rs2Data_R = '0; Valid_R = 1'b0;
      Rs1ForwardSrc = NO_FORWARD; Rs2ForwardSrc = NO_FORWARD;
      ComputeResult_M = '0; TruncatedResult_W = '0; StallRC = 1'b0; FlushCM = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0; StallRC = 1'b1; Valid_R = 1'b1;
      rs1Data_R = 32'hAAAA; rs2Data_R = 32'hBBBB;
      Rs1ForwardSrc = COMPUTE_RESULT; Rs2ForwardSrc = COMPUTE_RESULT;
      ComputeResult_M = 32'h1234;
      next_cycle(); next_cycle();
      #1;
      n_checks++; if (Valid_C !== 1'b0) begin n_fail++; $display("FAIL reset_valid_c: got %0h expected 0", Valid_C); end
      n_checks++; if (Valid_M !== 1'b0) begin n_fail++; $display("FAIL reset_valid_m: got %0h expected 0", Valid_M); end
      // LIVE state: compute forward passes straight through
      n_checks++; if (Rs1Op_C !== 32'h1234) begin n_fail++; $display("FAIL reset_live_fwd: got %0h expected 1234", Rs1Op_C); end
      Rs1ForwardSrc = NO_FORWARD; Rs2ForwardSrc = NO_FORWARD;
      #1;
      n_checks++; if (Rs1Op_C !== 32'h0) begin n_fail++; $display("FAIL reset_rs1_op: got %0h expected 0", Rs1Op_C); end
      n_checks++; if (Rs2Op_C !== 32'h0) begin n_fail++; $display("FAIL reset_rs2_op: got %0h expected 0", Rs2Op_C); end
      n_checks++; if (StallCycles !== 32'h0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0h expected 0", StallCycles); end
      n_checks++; if (ForwardCount !== 32'h0) begin n_fail++; $display("FAIL reset_fwd_cnt: got %0h expected 0", ForwardCount); end
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_plain_advance();
      rs1Data_R = 32'h11; rs2Data_R = 32'h22; Valid_R = 1'b1;
      next_cycle();
      rs1Data_R = 32'h0; rs2Data_R = 32'h0; Valid_R = 1'b0;
      #1;
      n_checks++; if (Rs1Op_C !== 32'h11) begin n_fail++; $display("FAIL adv_rs1: got %0h expected 11", Rs1Op_C); end
      n_checks++; if (Rs2Op_C !== 32'h22) begin n_fail++; $display("FAIL adv_rs2: got %0h expected 22", Rs2Op_C); end
      n_checks++; if (Valid_C !== 1'b1) begin n_fail++; $display("FAIL adv_valid_c: got %0h expected 1", Valid_C); end
      n_checks++; if (Valid_M !== 1'b0) begin n_fail++; $display("FAIL adv_valid_m0: got %0h expected 0", Valid_M); end
      next_cycle();
      n_checks++; if (Valid_M !== 1'b1) begin n_fail++; $display("FAIL adv_valid_m1: got %0h expected 1", Valid_M); end
      n_checks++; if (Valid_C !== 1'b0) begin n_fail++; $display("FAIL adv_valid_c0: got %0h expected 0", Valid_C); end
   endtask

   task automatic test_compute_forward();
      rs1Data_R = 32'h31; rs2Data_R = 32'h33; Valid_R = 1'b1;
      next_cycle();
      Rs2ForwardSrc = COMPUTE_RESULT; ComputeResult_M = 32'hAB;
      #1;
      n_checks++; if (Rs2Op_C !== 32'hAB) begin n_fail++; $display("FAIL cfwd_rs2: got %0h expected ab", Rs2Op_C); end
      n_checks++; if (Rs1Op_C !== 32'h31) begin n_fail++; $display("FAIL cfwd_rs1: got %0h expected 31", Rs1Op_C); end
      // Both operands forwarded from different sources at once
      Rs1ForwardSrc = TRUNCATED_RESULT; TruncatedResult_W = 32'h77;
      #1;
      n_checks++; if (Rs1Op_C !== 32'h77) begin n_fail++; $display("FAIL dual_rs1: got %0h expected 77", Rs1Op_C); end
      n_checks++; if (Rs2Op_C !== 32'hAB) begin n_fail++; $display("FAIL dual_rs2: got %0h expected ab", Rs2Op_C); end
      Rs1ForwardSrc = NO_FORWARD; Rs2ForwardSrc = NO_FORWARD;
      next_cycle();
   endtask

   task automatic test_held_stall();
      rs1Data_R = 32'h01; rs2Data_R = 32'h0A; Valid_R = 1'b1;
      next_cycle();
      // Stall cycle A: live compute forward, captured at this edge
      rs1Data_R = 32'h02; rs2Data_R = 32'h0B;
      Rs1ForwardSrc = COMPUTE_RESULT; ComputeResult_M = 32'h55; StallRC = 1'b1;
      #1;
      n_checks++; if (Rs1Op_C !== 32'h55) begin n_fail++; $display("FAIL hold_a: got %0h expected 55", Rs1Op_C); end
      next_cycle();
      ComputeResult_M = 32'h99;
      #1;
      n_checks++; if (Rs1Op_C !== 32'h55) begin n_fail++; $display("FAIL hold_b: got %0h expected 55", Rs1Op_C); end
      n_checks++; if (Rs2Op_C !== 32'h0A) begin n_fail++; $display("FAIL hold_rs2_kept: got %0h expected a", Rs2Op_C); end
      n_checks++; if (Valid_C !== 1'b1) begin n_fail++; $display("FAIL hold_valid_c: got %0h expected 1", Valid_C); end
      next_cycle();
      // Release cycle: instruction still consumes the held value
      StallRC = 1'b0;
      #1;
      n_checks++; if (Rs1Op_C !== 32'h55) begin n_fail++; $display("FAIL hold_release: got %0h expected 55", Rs1Op_C); end
      next_cycle();
      #1;
      n_checks++; if (Rs1Op_C !== 32'h99) begin n_fail++; $display("FAIL after_release_live: got %0h expected 99", Rs1Op_C); end
      Rs1ForwardSrc = NO_FORWARD;
      #1;
      n_checks++; if (Rs1Op_C !== 32'h02) begin n_fail++; $display("FAIL after_release_val: got %0h expected 2", Rs1Op_C); end
   endtask

   task automatic test_load_stall();
      rs1Data_R = 32'h40; Valid_R = 1'b1;
      next_cycle();
      // t0: stall + flush with truncated select
      rs1Data_R = 32'h41;
      StallRC = 1'b1; FlushCM = 1'b1; Rs1ForwardSrc = TRUNCATED_RESULT;
      TruncatedResult_W = 32'h1111; ComputeResult_M = 32'h2222;
      next_cycle();
      // t1: release, load data now on the W result
      StallRC = 1'b0; FlushCM = 1'b0; TruncatedResult_W = 32'hDEAD;
      #1;
      n_checks++; if (Valid_M !== 1'b0) begin n_fail++; $display("FAIL load_flush_valid_m: got %0h expected 0", Valid_M); end
      n_checks++; if (Rs1Op_C !== 32'hDEAD) begin n_fail++; $display("FAIL load_rs1: got %0h expected dead", Rs1Op_C); end
      n_checks++; if (Valid_C !== 1'b1) begin n_fail++; $display("FAIL load_valid_c: got %0h expected 1", Valid_C); end
      next_cycle();
      n_checks++; if (Valid_M !== 1'b1) begin n_fail++; $display("FAIL load_valid_m_adv: got %0h expected 1", Valid_M); end
      n_checks++; if (Rs1Op_C !== 32'hDEAD) begin n_fail++; $display("FAIL load_next_live: got %0h expected dead", Rs1Op_C); end
      Rs1ForwardSrc = NO_FORWARD;
      #1;
      n_checks++; if (Rs1Op_C !== 32'h41) begin n_fail++; $display("FAIL load_next_val: got %0h expected 41", Rs1Op_C); end
   endtask

   task automatic test_reset_during_stall();
      rs1Data_R = 32'h60; Valid_R = 1'b1;
      next_cycle();
      Rs1ForwardSrc = COMPUTE_RESULT; ComputeResult_M = 32'h66; StallRC = 1'b1;
      next_cycle();
      reset = 1'b0;
      next_cycle();
      reset = 1'b1; ComputeResult_M = 32'h67; Valid_R = 1'b0;
      #1;
      n_checks++; if (Rs1Op_C !== 32'h67) begin n_fail++; $display("FAIL rst_stall_live: got %0h expected 67", Rs1Op_C); end
      n_checks++; if (Valid_C !== 1'b0) begin n_fail++; $display("FAIL rst_stall_valid_c: got %0h expected 0", Valid_C); end
      Rs1ForwardSrc = NO_FORWARD;
      #1;
      n_checks++; if (Rs1Op_C !== 32'h0) begin n_fail++; $display("FAIL rst_stall_val: got %0h expected 0", Rs1Op_C); end
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_stats();
      logic [31:0] exp_stall, exp_fwd;
`ifdef FORWARD_STATS_EN
      exp_stall = 32'd3; exp_fwd = 32'd4;
`else
      exp_stall = 32'd0; exp_fwd = 32'd0;
`endif
      reset = 1'b0;
      next_cycle();
      reset = 1'b1; Valid_R = 1'b1; rs1Data_R = 32'h5;
      next_cycle();
      StallRC = 1'b1;
      for (int i = 0; i < 3; i++) next_cycle();
      StallRC = 1'b0; Rs1ForwardSrc = COMPUTE_RESULT;
      for (int i = 0; i < 4; i++) next_cycle();
      Rs1ForwardSrc = NO_FORWARD; Valid_R = 1'b0;
      #1;
      n_checks++; if (StallCycles !== exp_stall) begin n_fail++; $display("FAIL stats_stall: got %0d expected %0d", StallCycles, exp_stall); end
      n_checks++; if (ForwardCount !== exp_fwd) begin n_fail++; $display("FAIL stats_fwd: got %0d expected %0d", ForwardCount, exp_fwd); end
      next_cycle();
      n_checks++; if (ForwardCount !== exp_fwd) begin n_fail++; $display("FAIL stats_fwd_idle: got %0d expected %0d", ForwardCount, exp_fwd); end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_plain_advance();
      test_compute_forward();
      test_held_stall();
      test_load_stall();
      test_reset_during_stall();
      test_stats();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_forward_stage.md
# operand_forward_stage

Responder side of the hazard-unit protocol: owns the R→C operand pipeline register, applies the registered forward selects to produce the C-stage ALU operands, and obeys stall/flush commands. Sits between register-file read (R) and compute (C). Holds forwarded values across a stall so a moving forwarding source cannot corrupt the stalled instruction. Drives the C→M valid bit used to inject bubbles.

## Interface
- `WIDTH`, default `` `WORD_SIZE ``: operand/result width.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low; when 0 at a rising edge, block resets.
- `rs1Data_R`, `rs2Data_R`  in  WIDTH  register-file read data.
- `Valid_R`  in  1  R stage holds a real instruction.
- `Rs1ForwardSrc`, `Rs2ForwardSrc`  in  `HighLevelControl::rs1ForwardSrc` / `rs2ForwardSrc`  C-stage forward select: NO_FORWARD, COMPUTE_RESULT, TRUNCATED_RESULT.
- `ComputeResult_M`  in  WIDTH  result of the instruction one ahead of C.
- `TruncatedResult_W`  in  WIDTH  result of the instruction two ahead of C (load data included).
- `StallRC`  in  1  hold the R→C register.
- `FlushCM`  in  1  insert a bubble into M.
- `Rs1Op_C`, `Rs2Op_C`  out  WIDTH  final C-stage operands.
- `Valid_C`  out  1  C stage holds a real instruction.
- `Valid_M`  out  1  M stage holds a real instruction.
- `StallCycles`, `ForwardCount`  out  32  statistics (see Configuration).

## Operation
- Registers: `rs1Val_C`, `rs2Val_C`, `Valid_C`, `Valid_M`; per operand a hold register and a state bit, LIVE/HELD.
- R→C register: when StallRC=0, load `rs1Data_R`, `rs2Data_R`, `Valid_R`. When StallRC=1, keep the old value.
- Operand mux, per operand x:
  - HELD: output the hold register.
  - LIVE, NO_FORWARD: output `rsxVal_C`.
  - LIVE, COMPUTE_RESULT: output `ComputeResult_M`.
  - LIVE, TRUNCATED_RESULT: output `TruncatedResult_W`.
- Operand FSM, per operand:
  - LIVE→HELD on an edge where StallRC=1, Valid_C=1 and src=COMPUTE_RESULT. Capture `ComputeResult_M` into the hold register.
  - HELD→LIVE on any edge where StallRC=0.
  - HELD stays HELD while StallRC=1, and the hold register is unchanged.
  - TRUNCATED_RESULT is never captured. Its value is valid only on the cycle after the stall releases.
- Valid_M: FlushCM=1 forces 0, else `Valid_M <= Valid_C`.
  - FlushCM together with StallRC=0 is legal: C still advances and M gets a bubble.

## Timing
- Reset values: Valid_C=0, Valid_M=0, both operand FSMs LIVE, all value/hold registers 0. Therefore Rs1Op_C=Rs2Op_C=0 when src=NO_FORWARD, and StallCycles=ForwardCount=0.
- Reset has priority over StallRC and FlushCM. Reset during a stall returns the block to LIVE and discards the stalled instruction.
- Operand outputs are combinational from registers and M/W results. R-data reaches C operands 1 cycle after capture.
- The forward selects arrive already registered, so the block adds no latency to them.
- Load stall sequence (load one ahead, dependent instruction in C), cycles:
  - t0: StallRC=FlushCM=1, src=TRUNCATED. Operands are ignored downstream.
  - t1: StallRC=0, src=TRUNCATED. Rs1Op_C = load data on `TruncatedResult_W`.
- Simultaneous forwarding on both operands is allowed, including with different sources. Each FSM is independent.
- Operand FSM updates while Valid_C=0 are suppressed, so a bubble never enters HELD.

## Configuration
- `FORWARD_STATS_EN` defined:
  - `StallCycles` increments on every cycle with StallRC=1.
  - `ForwardCount` increments on every cycle with Valid_C=1, StallRC=0 and at least one src≠NO_FORWARD.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: both outputs constant 0 and no counter flops are generated.

## Test plan
- Reset: drive reset=0 for 2 cycles with StallRC=1 and src=COMPUTE → Valid_C=0, Valid_M=0, both FSMs LIVE; with src then NO_FORWARD, operands read 0.
- Plain advance: rs1Data_R=0x11, Valid_R=1, NO_FORWARD → next cycle Rs1Op_C=0x11, Valid_C=1; one cycle later Valid_M=1.
- Compute forward: rs2 src=COMPUTE, ComputeResult_M=0xAB → Rs2Op_C=0xAB that cycle.
- Held across stall: src=COMPUTE, ComputeResult_M=0x55, StallRC=1 for 2 cycles while ComputeResult_M changes to 0x99 → Rs1Op_C stays 0x55 on both stalled cycles, then follows the live mux after release.
- Load stall: StallRC=FlushCM=1 one cycle with src=TRUNCATED, then release with TruncatedResult_W=0xDEAD → Valid_M=0 after the flush edge, Rs1Op_C=0xDEAD in the release cycle.
- Statistics (with `FORWARD_STATS_EN`): 3 stall cycles plus 4 forwarded valid cycles → StallCycles=3, ForwardCount=4. Preload a counter to 0xFFFFFFFF and increment once → it reads 0.
